ex_stage: RTL and testbench

- Execute stage of the 5-stage integer pipeline; consumes the registered decode outputs of the ID/EX pipeline register and drives the EX/MEM register.
- Single-cycle logic, shift, arithmetic and HI/LO-move ops.
- Multi-cycle iterative DIV/DIVU engine; raises a stall request to the pipeline controller while the divide runs.

---
 rtl/ex_stage_if.sv | 31 +++
 rtl/ex_stage.sv | 225 ++++++++++++++++++++++
 tb/tb_ex_stage.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/ex_stage_if.sv
// Execute-stage signal bundle: ID/EX register outputs in, EX/MEM register inputs out.
// The slave modport is the execute stage; the master modport is the surrounding pipeline.
interface ex_stage_if #(parameter int DATA_W = 32);
    logic              flush_i;
    logic [7:0]        aluop_i;
    logic [2:0]        alusel_i;
    logic [DATA_W-1:0] reg1_i;
    logic [DATA_W-1:0] reg2_i;
    logic [4:0]        wd_i;
    logic              wreg_i;
    logic [DATA_W-1:0] hi_i;
    logic [DATA_W-1:0] lo_i;
    logic [4:0]        wd_o;
    logic              wreg_o;
    logic [DATA_W-1:0] wdata_o;
    logic              whilo_o;
    logic [DATA_W-1:0] hi_o;
    logic [DATA_W-1:0] lo_o;
    logic              stallreq_o;
    logic              ovf_o;

    modport slave (
        input  flush_i, aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, hi_i, lo_i,
        output wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o, ovf_o
    );

    modport master (
        output flush_i, aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, hi_i, lo_i,
        input  wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o, ovf_o
    );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU/shift/HI-LO moves plus an iterative restoring DIV/DIVU engine.
// Optional macro EX_OVF_CHECK_EN: signed overflow on ADD/SUB raises ovf_o and suppresses the GPR write.
module ex_stage #(
    parameter int DATA_W = 32
) (
    input logic     clk,
    input logic     rst,
    ex_stage_if.slave bus
);
    localparam int SH_W  = $clog2(DATA_W);
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
    localparam logic [2:0] EXE_RES_SHIFT = 3'b010;
    localparam logic [2:0] EXE_RES_MOVE  = 3'b011;
    localparam logic [2:0] EXE_RES_ARITH = 3'b100;

    localparam logic [7:0] EXE_AND_OP  = 8'b00100100;
    localparam logic [7:0] EXE_OR_OP   = 8'b00100101;
    localparam logic [7:0] EXE_XOR_OP  = 8'b00100110;
    localparam logic [7:0] EXE_NOR_OP  = 8'b00100111;
    localparam logic [7:0] EXE_SLL_OP  = 8'b01111100;
    localparam logic [7:0] EXE_SRL_OP  = 8'b00000010;
    localparam logic [7:0] EXE_SRA_OP  = 8'b00000011;
    localparam logic [7:0] EXE_SLT_OP  = 8'b00101010;
    localparam logic [7:0] EXE_SLTU_OP = 8'b00101011;
    localparam logic [7:0] EXE_ADD_OP  = 8'b00100000;
    localparam logic [7:0] EXE_ADDU_OP = 8'b00100001;
    localparam logic [7:0] EXE_SUB_OP  = 8'b00100010;
    localparam logic [7:0] EXE_SUBU_OP = 8'b00100011;
    localparam logic [7:0] EXE_MFHI_OP = 8'b00010000;
    localparam logic [7:0] EXE_MTHI_OP = 8'b00010001;
    localparam logic [7:0] EXE_MFLO_OP = 8'b00010010;
    localparam logic [7:0] EXE_MTLO_OP = 8'b00010011;
    localparam logic [7:0] EXE_DIV_OP  = 8'b00011010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b00011011;

    typedef enum logic [1:0] {DIV_IDLE, DIV_RUN, DIV_DONE} div_state_t;

    div_state_t        state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] quo;
    logic [DATA_W-1:0] rem;
    logic [DATA_W-1:0] dvs;
    logic              q_neg;
    logic              r_neg;

    logic              is_div;
    logic              is_sdiv;
    logic [DATA_W:0]   rem_sh;
    logic [DATA_W:0]   trial;
    logic signed [DATA_W-1:0] a_s;
    logic signed [DATA_W-1:0] b_s;
    logic signed [DATA_W-1:0] sum_s;
    logic signed [DATA_W-1:0] diff_s;
    logic [SH_W-1:0]   sh;
    logic [DATA_W-1:0] res;

    function automatic logic [DATA_W-1:0] apply_sign(input logic neg, input logic [DATA_W-1:0] v);
        return neg ? ('0 - v) : v;
    endfunction

    function automatic logic [DATA_W-1:0] magnitude(input logic signed [DATA_W-1:0] v);
        return apply_sign(v[DATA_W-1], v);
    endfunction

    assign is_sdiv = (bus.aluop_i == EXE_DIV_OP);
    assign is_div  = is_sdiv || (bus.aluop_i == EXE_DIVU_OP);
    assign a_s     = bus.reg1_i;
    assign b_s     = bus.reg2_i;
    assign sum_s   = a_s + b_s;
    assign diff_s  = a_s - b_s;
    assign sh      = bus.reg1_i[SH_W-1:0];

    // Trial subtraction; a clear top bit means the shifted remainder covers the divisor.
    assign rem_sh  = {rem, quo[DATA_W-1]};
    assign trial   = rem_sh - {1'b0, dvs};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= DIV_IDLE;
            cnt   <= '0;
            quo   <= '0;
            rem   <= '0;
            dvs   <= '0;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
        end else if (bus.flush_i) begin
            state <= DIV_IDLE;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (is_div) begin
                        if (bus.reg2_i == '0) begin
                            quo   <= '0;
                            rem   <= '0;
                            q_neg <= 1'b0;
                            r_neg <= 1'b0;
                            state <= DIV_DONE;
                        end else begin
                            quo   <= is_sdiv ? magnitude(a_s) : bus.reg1_i;
                            dvs   <= is_sdiv ? magnitude(b_s) : bus.reg2_i;
                            rem   <= '0;
                            cnt   <= '0;
                            q_neg <= is_sdiv & (bus.reg1_i[DATA_W-1] ^ bus.reg2_i[DATA_W-1]);
                            r_neg <= is_sdiv & bus.reg1_i[DATA_W-1];
                            state <= DIV_RUN;
                        end
                    end
                end
                DIV_RUN: begin
                    if (!trial[DATA_W]) begin
                        rem <= trial[DATA_W-1:0];
                        quo <= {quo[DATA_W-2:0], 1'b1};
                    end else begin
                        rem <= rem_sh[DATA_W-1:0];
                        quo <= {quo[DATA_W-2:0], 1'b0};
                    end
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) state <= DIV_DONE;
                end
                DIV_DONE: state <= DIV_IDLE;
                default:  state <= DIV_IDLE;
            endcase
        end
    end

    always_comb begin
        res = '0;
        case (bus.alusel_i)
            EXE_RES_LOGIC: begin
                case (bus.aluop_i)
                    EXE_AND_OP: res = bus.reg1_i & bus.reg2_i;
                    EXE_OR_OP:  res = bus.reg1_i | bus.reg2_i;
                    EXE_XOR_OP: res = bus.reg1_i ^ bus.reg2_i;
                    EXE_NOR_OP: res = ~(bus.reg1_i | bus.reg2_i);
                    default:    res = '0;
                endcase
            end
            EXE_RES_SHIFT: begin
                case (bus.aluop_i)
                    EXE_SLL_OP: res = bus.reg2_i << sh;
                    EXE_SRL_OP: res = bus.reg2_i >> sh;
                    EXE_SRA_OP: res = b_s >>> sh;
                    default:    res = '0;
                endcase
            end
            EXE_RES_ARITH: begin
                case (bus.aluop_i)
                    EXE_ADD_OP, EXE_ADDU_OP: res = sum_s;
                    EXE_SUB_OP, EXE_SUBU_OP: res = diff_s;
                    EXE_SLT_OP:  res = {{(DATA_W-1){1'b0}}, (a_s < b_s)};
                    EXE_SLTU_OP: res = {{(DATA_W-1){1'b0}}, (bus.reg1_i < bus.reg2_i)};
                    default:     res = '0;
                endcase
            end
            EXE_RES_MOVE: begin
                case (bus.aluop_i)
                    EXE_MFHI_OP: res = bus.hi_i;
                    EXE_MFLO_OP: res = bus.lo_i;
                    default:     res = '0;
                endcase
            end
            default: res = '0;
        endcase
    end

`ifdef EX_OVF_CHECK_EN
    logic add_ovf;
    logic sub_ovf;
    assign add_ovf = (a_s[DATA_W-1] == b_s[DATA_W-1]) && (sum_s[DATA_W-1] != a_s[DATA_W-1]);
    assign sub_ovf = (a_s[DATA_W-1] != b_s[DATA_W-1]) && (diff_s[DATA_W-1] != a_s[DATA_W-1]);
`endif

    always_comb begin
        bus.wd_o       = bus.wd_i;
        bus.wreg_o     = bus.wreg_i;
        bus.wdata_o    = res;
        bus.whilo_o    = 1'b0;
        bus.hi_o       = bus.hi_i;
        bus.lo_o       = bus.lo_i;
        bus.stallreq_o = 1'b0;
        bus.ovf_o      = 1'b0;
`ifdef EX_OVF_CHECK_EN
        if (((bus.aluop_i == EXE_ADD_OP) && add_ovf) || ((bus.aluop_i == EXE_SUB_OP) && sub_ovf)) begin
            bus.ovf_o  = 1'b1;
            bus.wreg_o = 1'b0;
        end
`endif
        if (bus.aluop_i == EXE_MTHI_OP) begin
            bus.whilo_o = 1'b1;
            bus.hi_o    = bus.reg1_i;
        end
        if (bus.aluop_i == EXE_MTLO_OP) begin
            bus.whilo_o = 1'b1;
            bus.lo_o    = bus.reg1_i;
        end
        if (is_div) bus.wreg_o = 1'b0;
        // Divider stall is combinational so the very first divide cycle already freezes the front end.
        case (state)
            DIV_IDLE: bus.stallreq_o = is_div & ~bus.flush_i;
            DIV_RUN:  bus.stallreq_o = ~bus.flush_i;
            DIV_DONE: begin
                if (!bus.flush_i) begin
                    bus.whilo_o = 1'b1;
                    bus.hi_o    = apply_sign(r_neg, rem);
                    bus.lo_o    = apply_sign(q_neg, quo);
                end
            end
            default: bus.stallreq_o = 1'b0;
        endcase
        if (rst) begin
            bus.wd_o       = '0;
            bus.wreg_o     = 1'b0;
            bus.wdata_o    = '0;
            bus.whilo_o    = 1'b0;
            bus.hi_o       = '0;
            bus.lo_o       = '0;
            bus.stallreq_o = 1'b0;
            bus.ovf_o      = 1'b0;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: stimulus queues hand-computed results, a negedge monitor
// pops one entry each time the stage presents an unstalled result and counts stall cycles.
module tb_ex_stage;
    localparam logic [2:0] NOP = 3'b000, LOGIC = 3'b001, SHIFT = 3'b010, MOVE = 3'b011, ARITH = 3'b100;
    localparam logic [7:0] AND_OP = 8'b00100100, OR_OP = 8'b00100101, XOR_OP = 8'b00100110;
    localparam logic [7:0] NOR_OP = 8'b00100111, SLL_OP = 8'b01111100, SRL_OP = 8'b00000010;
    localparam logic [7:0] SRA_OP = 8'b00000011, SLT_OP = 8'b00101010, SLTU_OP = 8'b00101011;
    localparam logic [7:0] ADD_OP = 8'b00100000, ADDU_OP = 8'b00100001, SUB_OP = 8'b00100010;
    localparam logic [7:0] SUBU_OP = 8'b00100011, MFHI_OP = 8'b00010000, MTHI_OP = 8'b00010001;
    localparam logic [7:0] MFLO_OP = 8'b00010010, MTLO_OP = 8'b00010011;
    localparam logic [7:0] DIV_OP = 8'b00011010, DIVU_OP = 8'b00011011;
    localparam logic [31:0] HI_V = 32'h11112222, LO_V = 32'h33334444;

    typedef struct {
        string       name;
        logic [31:0] wdata;
        logic [4:0]  wd;
        logic        wreg;
        logic        whilo;
        logic        chk_hl;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        ovf;
        int          stall;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic vld = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   scnt = 0;
    exp_t exp_q[$];
    exp_t e;

    ex_stage_if #(.DATA_W(32)) bus ();

    ex_stage #(.DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s actual=0x%08h required=0x%08h", nm, fld, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (vld && bus.stallreq_o) begin
            scnt++;
        end else if (vld) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output actual=0x%08h required=none", bus.wdata_o);
            end else begin
                e = exp_q.pop_front();
                chk(e.name, "wdata", bus.wdata_o, e.wdata);
                chk(e.name, "wd", 32'(bus.wd_o), 32'(e.wd));
                chk(e.name, "wreg", 32'(bus.wreg_o), 32'(e.wreg));
                chk(e.name, "whilo", 32'(bus.whilo_o), 32'(e.whilo));
                chk(e.name, "ovf", 32'(bus.ovf_o), 32'(e.ovf));
                chk(e.name, "stall_cycles", 32'(scnt), 32'(e.stall));
                if (e.chk_hl) begin
                    chk(e.name, "hi", bus.hi_o, e.hi);
                    chk(e.name, "lo", bus.lo_o, e.lo);
                end
            end
            scnt = 0;
        end
    end

    function automatic exp_t mk(input string n, input logic [31:0] wdata, input logic [4:0] wd,
                                input logic wreg, input logic whilo, input logic chk_hl,
                                input logic [31:0] hi, input logic [31:0] lo, input logic ovf, input int stall);
        exp_t r;
        r.name = n; r.wdata = wdata; r.wd = wd; r.wreg = wreg; r.whilo = whilo;
        r.chk_hl = chk_hl; r.hi = hi; r.lo = lo; r.ovf = ovf; r.stall = stall;
        return r;
    endfunction

    // Holds one operation until the stage stops stalling; abort_at injects flush (or rst) on that cycle.
    task automatic run_op(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] r1,
                          input logic [31:0] r2, input logic [4:0] wd, input logic wr,
                          input int abort_at, input bit use_rst, input exp_t ex);
        bit done = 1'b0;
        bus.aluop_i = op; bus.alusel_i = sel; bus.reg1_i = r1; bus.reg2_i = r2;
        bus.wd_i = wd; bus.wreg_i = wr;
        vld = 1'b1;
        exp_q.push_back(ex);
        for (int c = 1; c <= 100 && !done; c++) begin
            if (c == abort_at) begin
                if (use_rst) rst = 1'b1;
                else bus.flush_i = 1'b1;
            end
            @(negedge clk);
            if (!bus.stallreq_o) done = 1'b1;
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        bus.flush_i = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s.completion actual=stalled required=released_within_100", ex.name);
        end
    endtask

    task automatic alu(input string n, input logic [7:0] op, input logic [2:0] sel,
                       input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] res);
        run_op(op, sel, r1, r2, 5'd7, 1'b1, 0, 1'b0, mk(n, res, 5'd7, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.flush_i = 1'b0; bus.aluop_i = '0; bus.alusel_i = '0; bus.reg1_i = '0; bus.reg2_i = '0;
        bus.wd_i = '0; bus.wreg_i = 1'b0; bus.hi_i = HI_V; bus.lo_i = LO_V;
        repeat (2) @(posedge clk);
        #1;
        run_op(AND_OP, LOGIC, 32'hF0F000FF, 32'h0FF00F0F, 5'd5, 1'b1, 1, 1'b1,
               mk("reset", '0, 5'd0, 1'b0, 1'b0, 1'b1, '0, '0, 1'b0, 0));
        run_op(AND_OP, LOGIC, 32'hF0F000FF, 32'h0FF00F0F, 5'd5, 1'b1, 0, 1'b0,
               mk("and", 32'h00F0000F, 5'd5, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 0));
        alu("or",   OR_OP,   LOGIC, 32'hF0F000FF, 32'h0FF00F0F, 32'hFFF00FFF);
        alu("xor",  XOR_OP,  LOGIC, 32'hF0F000FF, 32'h0FF00F0F, 32'hFF000FF0);
        alu("nor",  NOR_OP,  LOGIC, 32'hF0F000FF, 32'h0FF00F0F, 32'h000FF000);
        alu("sll",  SLL_OP,  SHIFT, 32'h00000024, 32'h80000001, 32'h00000010);
        alu("srl",  SRL_OP,  SHIFT, 32'h00000004, 32'h80000000, 32'h08000000);
        alu("sra",  SRA_OP,  SHIFT, 32'h00000004, 32'h80000000, 32'hF8000000);
        alu("addu", ADDU_OP, ARITH, 32'hFFFFFFFF, 32'h00000002, 32'h00000001);
        alu("subu", SUBU_OP, ARITH, 32'h00000001, 32'h00000002, 32'hFFFFFFFF);
        alu("slt",  SLT_OP,  ARITH, 32'hFFFFFFFF, 32'h00000001, 32'h00000001);
        alu("sltu", SLTU_OP, ARITH, 32'hFFFFFFFF, 32'h00000001, 32'h00000000);
        alu("add_ok", ADD_OP, ARITH, 32'h00000005, 32'hFFFFFFFD, 32'h00000002);
        alu("mfhi", MFHI_OP, MOVE,  32'h0, 32'h0, HI_V);
        alu("mflo", MFLO_OP, MOVE,  32'h0, 32'h0, LO_V);
        alu("badsel", AND_OP, 3'b111, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0);
        run_op(MTHI_OP, NOP, 32'hDEADBEEF, 32'h0, 5'd0, 1'b0, 0, 1'b0,
               mk("mthi", '0, 5'd0, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF, LO_V, 1'b0, 0));
        run_op(MTLO_OP, NOP, 32'hCAFEF00D, 32'h0, 5'd0, 1'b0, 0, 1'b0,
               mk("mtlo", '0, 5'd0, 1'b0, 1'b1, 1'b1, HI_V, 32'hCAFEF00D, 1'b0, 0));
`ifdef EX_OVF_CHECK_EN
        run_op(ADD_OP, ARITH, 32'h7FFFFFFF, 32'h1, 5'd9, 1'b1, 0, 1'b0,
               mk("add_ovf", 32'h80000000, 5'd9, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 0));
        run_op(SUB_OP, ARITH, 32'h80000000, 32'h1, 5'd9, 1'b1, 0, 1'b0,
               mk("sub_ovf", 32'h7FFFFFFF, 5'd9, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 0));
`else
        run_op(ADD_OP, ARITH, 32'h7FFFFFFF, 32'h1, 5'd9, 1'b1, 0, 1'b0,
               mk("add_ovf", 32'h80000000, 5'd9, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 0));
        run_op(SUB_OP, ARITH, 32'h80000000, 32'h1, 5'd9, 1'b1, 0, 1'b0,
               mk("sub_ovf", 32'h7FFFFFFF, 5'd9, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 0));
`endif
        run_op(DIV_OP, NOP, 32'hFFFFFFF9, 32'h2, 5'd3, 1'b1, 0, 1'b0,
               mk("div_m7_2", '0, 5'd3, 1'b0, 1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33));
        run_op(DIV_OP, NOP, 32'h00000007, 32'hFFFFFFFE, 5'd3, 1'b1, 0, 1'b0,
               mk("div_7_m2", '0, 5'd3, 1'b0, 1'b1, 1'b1, 32'h00000001, 32'hFFFFFFFD, 1'b0, 33));
        run_op(DIVU_OP, NOP, 32'hFFFFFFFF, 32'h0, 5'd3, 1'b1, 0, 1'b0,
               mk("divu_by0", '0, 5'd3, 1'b0, 1'b1, 1'b1, '0, '0, 1'b0, 1));
        run_op(DIVU_OP, NOP, 32'd100, 32'd7, 5'd3, 1'b1, 11, 1'b0,
               mk("divu_flush", '0, 5'd3, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 10));
        run_op(DIVU_OP, NOP, 32'd100, 32'd7, 5'd3, 1'b1, 0, 1'b0,
               mk("divu_100_7", '0, 5'd3, 1'b0, 1'b1, 1'b1, 32'd2, 32'd14, 1'b0, 33));
        run_op(DIVU_OP, NOP, 32'd100, 32'd7, 5'd3, 1'b1, 6, 1'b1,
               mk("divu_rst", '0, 5'd0, 1'b0, 1'b0, 1'b1, '0, '0, 1'b0, 5));
        run_op(DIVU_OP, NOP, 32'h80000000, 32'd3, 5'd3, 1'b1, 0, 1'b0,
               mk("divu_big", '0, 5'd3, 1'b0, 1'b1, 1'b1, 32'd2, 32'h2AAAAAAA, 1'b0, 33));
        vld = 1'b0;
        repeat (2) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d pending required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
